// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem read at a time,
// FIFO instruction buffer toward decode, redirect flush and fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DROP,
    S_FAULT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;
  logic [31:0]   r_buf_instr [DEPTH];
  logic [31:0]   r_buf_pc    [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_fault;

  logic w_mis;
  logic w_fault_eff;
  logic w_req;
  logic w_push;
  logic w_pop;

  assign w_mis       = redirect && (redirect_pc[1:0] != 2'b00);
  assign w_fault_eff = redirect ? w_mis : r_fault;

  // credit rule: never request unless the response has a free slot
  assign w_req = !rst && (r_state == S_FETCH) && !redirect
              && (r_count < FULL);

  assign w_push = (r_state == S_WAIT) && imem_rvalid && !redirect;
  assign w_pop  = (r_count != '0) && instr_ready && !redirect;

  assign imem_req    = w_req;
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = (r_count != '0);
  assign instr       = r_buf_instr[r_rptr];
  assign instr_pc    = r_buf_pc[r_rptr];
  assign fetch_fault = r_fault;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FETCH: begin
        if (redirect)
          w_state_nxt = w_mis ? S_FAULT : S_FETCH;
        else if (w_req && imem_gnt)
          w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect && !imem_rvalid)
          w_state_nxt = S_DROP;
        else if (redirect)
          w_state_nxt = w_mis ? S_FAULT : S_FETCH;
        else if (imem_rvalid)
          w_state_nxt = S_FETCH;
      end
      S_DROP: begin
        if (imem_rvalid)
          w_state_nxt = w_fault_eff ? S_FAULT : S_FETCH;
      end
      S_FAULT: begin
        if (redirect && !w_mis)
          w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RST_PC;
      r_req_pc   <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_fault    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_instr[i] <= '0;
        r_buf_pc[i]    <= '0;
      end
    end else if (redirect) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_fault    <= w_mis;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_req && imem_gnt) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_req_pc   <= r_fetch_pc;
      end
      if (w_push) begin
        r_buf_instr[r_wptr] <= imem_rdata;
        r_buf_pc[r_wptr]    <= r_req_pc;
        r_wptr              <= r_wptr + AW'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      unique case (1'b1)
        w_push && !w_pop: r_count <= r_count + (AW+1)'(1);
        w_pop && !w_push: r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic,
// checked against a stream-level reference model.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .fetch_fault (fetch_fault)
  );

  // memory side
  bit          mem_busy;
  int          mem_lat;
  int          lat_cfg;
  bit          lat_rand;
  logic [31:0] mem_addr;

  // reference model: expected instruction stream and request stream
  logic [31:0] m_q[$];
  logic [31:0] m_req_pc;
  logic [31:0] m_out_pc;
  bit          m_out;
  bit          m_stale;
  bit          m_fault;

  logic [31:0] seen_pc[$];
  logic [31:0] grants[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$],
                                      input int i);
    return (i < q.size()) ? q[i] : 32'hBAD0_BAD0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit exp_req;
    bit pop;
    #3;
    if (rst) begin
      chk("rst_req", 32'(imem_req), 32'd0);
      m_q.delete();
      m_req_pc = RPC;
      m_out    = 0;
      m_stale  = 0;
      m_fault  = 0;
      mem_busy = 0;
    end else begin
      exp_req = !m_out && !m_fault && !redirect && (m_q.size() < DEPTH);
      chk("req", 32'(imem_req), 32'(exp_req));
      if (exp_req && imem_req) chk("addr", imem_addr, m_req_pc);
      chk("valid", 32'(instr_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0 && instr_valid) begin
        chk("head_pc", instr_pc, m_q[0]);
        chk("head_instr", instr, word_at(m_q[0]));
      end
      chk("fault", 32'(fetch_fault), 32'(m_fault));
      if (imem_req && imem_gnt) grants.push_back(imem_addr);
      pop = instr_ready && (m_q.size() != 0) && !redirect;
      if (redirect) begin
        m_q.delete();
        m_req_pc = {redirect_pc[31:2], 2'b00};
        m_fault  = (redirect_pc[1:0] != 2'b00);
        if (m_out && !imem_rvalid) m_stale = 1;
        else begin
          m_out   = 0;
          m_stale = 0;
        end
      end else begin
        if (pop) begin
          seen_pc.push_back(m_q[0]);
          void'(m_q.pop_front());
        end
        if (imem_rvalid && m_out) begin
          if (!m_stale) m_q.push_back(m_out_pc);
          m_out   = 0;
          m_stale = 0;
        end
        if (exp_req && imem_gnt) begin
          m_out    = 1;
          m_stale  = 0;
          m_out_pc = m_req_pc;
          m_req_pc = m_req_pc + 32'd4;
        end
      end
      if (imem_rvalid) mem_busy = 0;
      if (imem_req && imem_gnt) begin
        mem_busy = 1;
        mem_addr = imem_addr;
        mem_lat  = lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
      end
    end
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_busy) begin
      if (mem_lat == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(mem_addr);
      end else begin
        mem_lat--;
      end
    end
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    lat_cfg = 0; lat_rand = 0; mem_busy = 0; mem_lat = 0; mem_addr = '0;
    m_req_pc = RPC; m_out_pc = '0; m_out = 0; m_stale = 0; m_fault = 0;

    // reset state
    step(); step();
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);

    // first request right after reset release
    rst = 1'b0;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, RPC);
    repeat (12) step();
    chk("order0", qat(seen_pc, 0), 32'h0);
    chk("order1", qat(seen_pc, 1), 32'h4);
    chk("order2", qat(seen_pc, 2), 32'h8);

    // one instruction per two cycles at 1-cycle latency
    grants.delete();
    repeat (20) step();
    chk("throughput", 32'(grants.size()), 32'd10);

    // stall: buffer fills with two entries, requests stop
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    instr_ready = 1'b0;
    grants.delete();
    repeat (10) step();
    chk("stall_count", 32'(grants.size()), 32'd2);
    chk("stall_g0", qat(grants, 0), 32'h0);
    chk("stall_g1", qat(grants, 1), 32'h4);
    #1;
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("hold_pc", instr_pc, 32'h0);
    chk("hold_instr", instr, word_at(32'h0));

    // resume at 0x8 with slow memory, then redirect while it is in flight
    instr_ready = 1'b1;
    lat_cfg = 2;
    grants.delete();
    repeat (6) if (grants.size() == 0) step();
    chk("resume_addr", qat(grants, 0), 32'h8);
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    lat_cfg = 0;
    grants.delete();
    seen_pc.delete();
    repeat (20) if (seen_pc.size() == 0) step();
    chk("redir_addr", qat(grants, 0), 32'h100);
    chk("redir_pc", qat(seen_pc, 0), 32'h100);

    // misaligned target faults and blocks requests
    redirect = 1'b1; redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
    #1;
    chk("fault_set", 32'(fetch_fault), 32'd1);
    grants.delete();
    repeat (6) step();
    chk("fault_noreq", 32'(grants.size()), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    #1;
    chk("fault_clr", 32'(fetch_fault), 32'd0);
    chk("fault_exit_req", 32'(imem_req), 32'd1);
    chk("fault_exit_addr", imem_addr, 32'h200);

    // address wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    grants.delete();
    repeat (6) step();
    chk("wrap_g0", qat(grants, 0), 32'hFFFF_FFFC);
    chk("wrap_g1", qat(grants, 1), 32'h0);

    // reset with a full buffer
    instr_ready = 1'b0;
    repeat (8) step();
    #1;
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    rst = 1'b1;
    step();
    chk("rst_flush_valid", 32'(instr_valid), 32'd0);
    chk("rst_flush_addr", imem_addr, RPC);
    rst = 1'b0;
    instr_ready = 1'b1;

    // random traffic
    lat_rand = 1;
    for (int n = 0; n < 3000; n++) begin
      imem_gnt    = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8
                                                : ($urandom & 32'h0000_0FFC);
      if ($urandom_range(0, 4) == 0)
        redirect_pc[1:0] = 2'($urandom_range(1, 3));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
